// File: rtl/leiwand_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// leiwand_rv32_mem_arbiter
//
// Two-master, one-slave arbiter for the core's valid/ready memory bus.
// Master 0 is the core, master 1 a second bus master (debug loader / DMA).
// Grants are round-robin and held for a whole transaction. A programmable
// timeout completes a transaction on the master side if the slave never
// answers, so a requester can never hang on a dead slave.
//
// Handshake (both sides): a requester raises valid and holds it, together with
// addr/wdata/wen, until it sees ready. Ready is a single-cycle completion pulse.
// Read data is only meaningful while ready is high and is 0 otherwise.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_mX_valid/addr/wdata/wen   master X request (X = 0, 1)
//   o_mX_ready/rdata      master X completion and read data
//   o_s_valid/addr/wdata/wen    request towards the slave
//   i_s_ready/rdata       slave completion and read data
//   o_timeout             one-cycle pulse when a transaction is timed out
//   o_dbg_state           current arbiter state (0 IDLE, 1 GNT0, 2 GNT1)
//
// Parameters:
//   XLEN            bus address/data width
//   TIMEOUT_CYCLES  max GNT cycles waiting for i_s_ready; 0 disables it
// -----------------------------------------------------------------------------
module leiwand_rv32_mem_arbiter #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,

   input  logic              i_m0_valid,
   output logic              o_m0_ready,
   input  logic [XLEN-1:0]   i_m0_addr,
   input  logic [XLEN-1:0]   i_m0_wdata,
   input  logic [XLEN/8-1:0] i_m0_wen,
   output logic [XLEN-1:0]   o_m0_rdata,

   input  logic              i_m1_valid,
   output logic              o_m1_ready,
   input  logic [XLEN-1:0]   i_m1_addr,
   input  logic [XLEN-1:0]   i_m1_wdata,
   input  logic [XLEN/8-1:0] i_m1_wen,
   output logic [XLEN-1:0]   o_m1_rdata,

   output logic              o_s_valid,
   input  logic              i_s_ready,
   output logic [XLEN-1:0]   o_s_addr,
   output logic [XLEN-1:0]   o_s_wdata,
   output logic [XLEN/8-1:0] o_s_wen,
   input  logic [XLEN-1:0]   i_s_rdata,

   output logic              o_timeout,
   output logic [1:0]        o_dbg_state
);

   // A zero-width counter is not legal, so keep at least one bit even when
   // the timeout is disabled.
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic          TMO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [TW-1:0] TCNT_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t        state;
   logic          last;     // master served most recently
   logic [TW-1:0] tcnt;     // GNT cycles already spent waiting on the slave

   logic gnt_valid;         // the granted master's request is still up
   logic done;              // slave completes this cycle
   logic tmo;               // transaction is aborted by timeout this cycle

   assign o_dbg_state = state;

   // -------------------------------------------------------------------------
   // Completion / timeout detection. A dropped valid suppresses both, so a
   // master that withdraws its request never receives a ready pulse. Slave
   // completion in the last allowed cycle wins over the timeout.
   // -------------------------------------------------------------------------
   always_comb begin
      gnt_valid = 1'b0;
      case (state)
         GNT0:    gnt_valid = i_m0_valid;
         GNT1:    gnt_valid = i_m1_valid;
         default: gnt_valid = 1'b0;
      endcase
      done = gnt_valid & i_s_ready;
      tmo  = gnt_valid & ~i_s_ready & TMO_EN & (tcnt == TCNT_LAST);
   end

   // -------------------------------------------------------------------------
   // Output steering. Everything is a pure decode of the state register and
   // the current inputs, so the ready pulse is zero-latency from i_s_ready and
   // an asynchronous reset clears every output immediately.
   // -------------------------------------------------------------------------
   always_comb begin
      o_s_valid  = 1'b0;
      o_s_addr   = '0;
      o_s_wdata  = '0;
      o_s_wen    = '0;
      o_m0_ready = 1'b0;
      o_m0_rdata = '0;
      o_m1_ready = 1'b0;
      o_m1_rdata = '0;
      o_timeout  = 1'b0;
      case (state)
         GNT0: begin
            o_s_addr   = i_m0_addr;
            o_s_wdata  = i_m0_wdata;
            o_s_wen    = i_m0_wen;
            // The slave must not see a request in the cycle we give up on it.
            o_s_valid  = i_m0_valid & ~tmo;
            o_m0_ready = done | tmo;
            o_m0_rdata = done ? i_s_rdata : '0;
            o_timeout  = tmo;
         end
         GNT1: begin
            o_s_addr   = i_m1_addr;
            o_s_wdata  = i_m1_wdata;
            o_s_wen    = i_m1_wen;
            o_s_valid  = i_m1_valid & ~tmo;
            o_m1_ready = done | tmo;
            o_m1_rdata = done ? i_s_rdata : '0;
            o_timeout  = tmo;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Arbitration FSM. Every transaction ends in IDLE, which gives the
   // mandatory bubble between grants and the single point where round-robin
   // is decided. last resets to 1 so master 0 wins the first tie.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IDLE;
         last  <= 1'b1;
         tcnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               tcnt <= '0;
               if (i_m0_valid && i_m1_valid) begin
                  state <= last ? GNT0 : GNT1;
               end else if (i_m0_valid) begin
                  state <= GNT0;
               end else if (i_m1_valid) begin
                  state <= GNT1;
               end
            end
            GNT0, GNT1: begin
               if (!gnt_valid || done || tmo) begin
                  state <= IDLE;
                  last  <= (state == GNT1);
                  tcnt  <= '0;
               end else begin
                  tcnt  <= tcnt + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_leiwand_rv32_mem_arbiter
//
// Directed plus randomized test of the two-master arbiter. Expected grant
// order comes from the round-robin rule, expected completion cycle from the
// slave latency chosen per transaction (or the timeout limit), and expected
// read data from a reference memory updated with what the masters intended to
// write. The slave responder keeps its own memory, written only through the
// arbiter's slave-side outputs, so corrupted forwarding shows up on read-back.
// -----------------------------------------------------------------------------
module tb_leiwand_rv32_mem_arbiter;

   localparam int XLEN = 32;
   localparam int TMO  = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic i_rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic            i_m0_valid, o_m0_ready;
   logic [31:0]     i_m0_addr, i_m0_wdata, o_m0_rdata;
   logic [3:0]      i_m0_wen;
   logic            i_m1_valid, o_m1_ready;
   logic [31:0]     i_m1_addr, i_m1_wdata, o_m1_rdata;
   logic [3:0]      i_m1_wen;
   logic            o_s_valid, i_s_ready;
   logic [31:0]     o_s_addr, o_s_wdata, i_s_rdata;
   logic [3:0]      o_s_wen;
   logic            o_timeout;
   logic [1:0]      o_dbg_state;

   leiwand_rv32_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_m0_valid  (i_m0_valid),
      .o_m0_ready  (o_m0_ready),
      .i_m0_addr   (i_m0_addr),
      .i_m0_wdata  (i_m0_wdata),
      .i_m0_wen    (i_m0_wen),
      .o_m0_rdata  (o_m0_rdata),
      .i_m1_valid  (i_m1_valid),
      .o_m1_ready  (o_m1_ready),
      .i_m1_addr   (i_m1_addr),
      .i_m1_wdata  (i_m1_wdata),
      .i_m1_wen    (i_m1_wen),
      .o_m1_rdata  (o_m1_rdata),
      .o_s_valid   (o_s_valid),
      .i_s_ready   (i_s_ready),
      .o_s_addr    (o_s_addr),
      .o_s_wdata   (o_s_wdata),
      .o_s_wen     (o_s_wen),
      .i_s_rdata   (i_s_rdata),
      .o_timeout   (o_timeout),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] exp_q[$];

   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];

   bit          pending [2];
   logic [31:0] cur_addr [2];
   logic [31:0] cur_wdata [2];
   logic [3:0]  cur_wen [2];
   int          last_tb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] wen);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_masters();
      i_m0_valid = pending[0];
      i_m0_addr  = cur_addr[0];
      i_m0_wdata = cur_wdata[0];
      i_m0_wen   = cur_wen[0];
      i_m1_valid = pending[1];
      i_m1_addr  = cur_addr[1];
      i_m1_wdata = cur_wdata[1];
      i_m1_wen   = cur_wen[1];
   endtask

   task automatic set_txn(input int m, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] wen);
      pending[m]   = 1'b1;
      cur_addr[m]  = addr;
      cur_wdata[m] = wd;
      cur_wen[m]   = wen;
   endtask

   task automatic new_txn(input int m);
      logic [31:0] a;
      logic [3:0]  w;
      a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      case ($urandom_range(0, 2))
         0:       w = 4'h0;
         1:       w = 4'hF;
         default: w = 4'($urandom_range(0, 15));
      endcase
      set_txn(m, a, $urandom, w);
   endtask

   // Round-robin rule: with both requesting, serve the one not served last.
   function automatic int pick();
      if (pending[0] && pending[1]) return (last_tb == 0) ? 1 : 0;
      else if (pending[0])          return 0;
      else                          return 1;
   endfunction

   // A cycle with no requests: nothing may reach either side, even if the
   // slave raises a stray ready.
   task automatic idle_cycle();
      drive_masters();
      i_s_ready = 1'($urandom_range(0, 1));
      i_s_rdata = $urandom;
      @(negedge clk);
      chk("idle_s_valid", 32'(o_s_valid), 0);
      chk("idle_m0_ready", 32'(o_m0_ready), 0);
      chk("idle_m1_ready", 32'(o_m1_ready), 0);
      chk("idle_m0_rdata", o_m0_rdata, 0);
      chk("idle_timeout", 32'(o_timeout), 0);
      @(posedge clk); #1;
      i_s_ready = 1'b0;
   endtask

   // One full transaction for master m, started just after a rising edge with
   // the arbiter in IDLE. lat = GNT cycle in which the slave readies
   // (1..TMO completes; 0 or > TMO means the slave stays silent -> timeout).
   task automatic do_txn(input int m, input int lat);
      int          done_at;
      bit          tmo;
      int          idx;
      logic [31:0] exp_rd;
      logic        rdy_m, rdy_o;
      logic [31:0] rd_m, rd_o;
      tmo     = !(lat >= 1 && lat <= TMO);
      done_at = tmo ? TMO : lat;
      idx     = int'(cur_addr[m][5:2]);
      exp_q.push_back(ref_mem[idx]);
      drive_masters();
      i_s_ready = 1'b0;
      i_s_rdata = $urandom;
      @(negedge clk);
      chk("arb_cycle_s_valid", 32'(o_s_valid), 0);
      chk("arb_cycle_ready", {30'd0, o_m1_ready, o_m0_ready}, 0);
      for (int k = 1; k <= done_at; k++) begin
         @(posedge clk); #1;
         i_s_ready = !tmo && (k == done_at);
         i_s_rdata = i_s_ready ? slv_mem[o_s_addr[5:2]] : $urandom;
         @(negedge clk);
         rdy_m = (m == 0) ? o_m0_ready : o_m1_ready;
         rdy_o = (m == 0) ? o_m1_ready : o_m0_ready;
         rd_m  = (m == 0) ? o_m0_rdata : o_m1_rdata;
         rd_o  = (m == 0) ? o_m1_rdata : o_m0_rdata;
         chk("s_valid", 32'(o_s_valid), 32'(!(tmo && k == done_at)));
         chk("s_addr", o_s_addr, cur_addr[m]);
         chk("s_wdata", o_s_wdata, cur_wdata[m]);
         chk("s_wen", 32'(o_s_wen), 32'(cur_wen[m]));
         chk("granted_ready", 32'(rdy_m), 32'(k == done_at));
         chk("other_ready", 32'(rdy_o), 0);
         chk("other_rdata", rd_o, 0);
         chk("timeout", 32'(o_timeout), 32'(tmo && k == done_at));
         if (k == done_at) begin
            exp_rd = exp_q.pop_front();
            chk("granted_rdata", rd_m, tmo ? 32'd0 : exp_rd);
            if (!tmo) begin
               // slave side: commit what the arbiter actually forwarded
               slv_mem[o_s_addr[5:2]] = merge(slv_mem[o_s_addr[5:2]], o_s_wdata, o_s_wen);
               ref_mem[idx] = merge(ref_mem[idx], cur_wdata[m], cur_wen[m]);
            end
         end else begin
            chk("granted_rdata_idle", rd_m, 0);
         end
      end
      @(posedge clk); #1;
      i_s_ready  = 1'b0;
      pending[m] = 1'b0;
      last_tb    = m;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int m;
      i_rst     = 1'b0;
      i_s_ready = 1'b0;
      i_s_rdata = '0;
      last_tb   = 1;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         slv_mem[i] = ref_mem[i];
      end
      ref_mem[4] = 32'hDEAD_BEEF;
      slv_mem[4] = 32'hDEAD_BEEF;
      pending[0] = 1'b0;
      pending[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cur_addr[i] = '0; cur_wdata[i] = '0; cur_wen[i] = '0;
      end

      // Reset with both masters requesting: everything stays quiet.
      set_txn(0, 32'h8000_0000, 32'h0, 4'h0);
      set_txn(1, 32'h8000_0020, 32'h1111_0001, 4'hF);
      drive_masters();
      i_s_ready = 1'b1;
      i_s_rdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_valid", 32'(o_s_valid), 0);
      chk("rst_s_addr", o_s_addr, 0);
      chk("rst_s_wdata", o_s_wdata, 0);
      chk("rst_s_wen", 32'(o_s_wen), 0);
      chk("rst_m0_ready", 32'(o_m0_ready), 0);
      chk("rst_m1_ready", 32'(o_m1_ready), 0);
      chk("rst_m0_rdata", o_m0_rdata, 0);
      chk("rst_m1_rdata", o_m1_rdata, 0);
      chk("rst_timeout", 32'(o_timeout), 0);
      @(posedge clk); #1;
      i_s_ready = 1'b0;
      i_rst     = 1'b1;

      // Contention: 4 reads from M0, 4 full-word writes from M1, strictly
      // alternating starting with M0.
      for (int i = 0; i < 8; i++) begin
         m = i % 2;
         if (!pending[m]) begin
            if (m == 0) set_txn(0, 32'h8000_0000 | 32'((i / 2) << 2), $urandom, 4'h0);
            else        set_txn(1, 32'h8000_0020 | 32'((i / 2) << 2), $urandom, 4'hF);
         end
         chk("rr_order", 32'(pick()), 32'(m));
         do_txn(m, 1 + (i % 3));
      end

      // M0 reads back what M1 wrote.
      for (int i = 0; i < 4; i++) begin
         set_txn(0, 32'h8000_0020 | 32'(i << 2), 32'h0, 4'h0);
         do_txn(0, 1);
      end

      // Single read of 0x80000010, slave ready on 2nd valid cycle.
      set_txn(0, 32'h8000_0010, 32'h0, 4'h0);
      do_txn(0, 2);

      // Silent slave: timeout in the 8th GNT cycle, then a normal read.
      set_txn(0, 32'h8000_0010, 32'h0, 4'h0);
      do_txn(0, 0);
      set_txn(0, 32'h8000_0010, 32'h0, 4'h0);
      do_txn(0, 3);

      // Ready exactly in the 8th GNT cycle: completion beats timeout.
      set_txn(0, 32'h8000_0010, 32'h0, 4'h0);
      do_txn(0, TMO);

      // Reset while M1 is granted.
      set_txn(1, 32'h8000_0030, 32'h0, 4'h0);
      drive_masters();
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_pre_s_valid", 32'(o_s_valid), 1);
      #1 i_rst = 1'b0;
      #1;
      chk("mid_rst_s_valid", 32'(o_s_valid), 0);
      chk("mid_rst_m1_ready", 32'(o_m1_ready), 0);
      chk("mid_rst_s_addr", o_s_addr, 0);
      set_txn(0, 32'h8000_0010, 32'h0, 4'h0);
      drive_masters();
      @(posedge clk); #1;
      i_rst   = 1'b1;
      last_tb = 1;
      chk("rr_after_rst", 32'(pick()), 0);
      do_txn(0, 1);
      do_txn(1, 2);

      // Randomized traffic with random request patterns and slave latencies.
      for (int t = 0; t < 80; t++) begin
         for (int q = 0; q < 2; q++)
            if (!pending[q] && $urandom_range(0, 3) != 0) new_txn(q);
         if (!pending[0] && !pending[1]) idle_cycle();
         else do_txn(pick(), $urandom_range(0, 10));
      end

      // Read back every word: the slave memory, written only through the
      // arbiter, must match the reference memory.
      for (int i = 0; i < 16; i++) begin
         set_txn(1, 32'h8000_0000 | 32'(i << 2), 32'h0, 4'h0);
         do_txn(1, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
